// File: rtl/instruction_sequencer.sv
// Sequencer that fetches 20-bit words from a 16-entry program store and presents them to an executor.
// Resolves HALT/JMP/BZ/BNZ locally. Program loads are accepted only while idle.
module instruction_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [3:0]  load_addr,
  input  logic [19:0] load_data,
  input  logic        start,
  input  logic        stop,
  input  logic        z_flag,
  output logic [19:0] instruction,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BZ   = 4'h6;
  localparam logic [3:0] OP_BNZ  = 4'h7;

  state_e      state_q;
  logic [3:0]  pc_q;
  logic        done_q;
  logic [19:0] mem_q [16];

  logic [3:0]  cur_op;
  logic [3:0]  target;
  logic [3:0]  pc_inc;
  logic [3:0]  pc_d;

  assign cur_op = mem_q[pc_q][19:16];
  assign target = mem_q[pc_q][3:0];
  assign pc_inc = pc_q + 4'd1;

  // z_flag is only meaningful for the branch currently presented, so it is consumed here.
  always_comb begin
    pc_d = pc_inc;
    case (cur_op)
      OP_JMP:  pc_d = target;
      OP_BZ:   if (z_flag)  pc_d = target;
      OP_BNZ:  if (!z_flag) pc_d = target;
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= 4'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 20'h00000;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            mem_q[load_addr] <= load_data;
          end
          if (start && !stop) begin
            state_q <= S_RUN;
            pc_q    <= 4'd0;
          end
        end
        S_RUN: begin
          // stop outranks HALT and branches; pc is frozen on either exit
          if (stop) begin
            state_q <= S_IDLE;
          end else if (cur_op == OP_HALT) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_ready  = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign pc          = pc_q;
  assign done        = done_q;
  assign instruction = (state_q == S_RUN) ? mem_q[pc_q] : 20'h00000;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized and directed bench for instruction_sequencer against a behavioural program-execution model.
module tb_instruction_sequencer;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic        stop;
  logic        z_flag;
  logic [19:0] instruction;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  instruction_sequencer dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .start(start), .stop(stop), .z_flag(z_flag),
    .instruction(instruction), .pc(pc), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a program array, a running flag, a program counter, a done flag.
  logic [19:0] m_mem [16];
  bit          m_run;
  int          m_pc;
  bit          m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 20'h0;
    m_run = 0; m_pc = 0; m_done = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".instr"}, {12'h0, instruction}, m_run ? {12'h0, m_mem[m_pc]} : 32'h0);
    chk({tag, ".pc"}, {28'h0, pc}, m_pc);
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, m_run});
    chk({tag, ".ready"}, {31'h0, load_ready}, {31'h0, !m_run});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, m_done});
  endtask

  // Check current outputs, clock once, then advance the model by one instruction.
  task automatic step();
    bit          n_run;
    int          n_pc;
    bit          n_done;
    logic [19:0] w;
    check_outputs("step");
    n_run = m_run; n_pc = m_pc; n_done = 0;
    if (!m_run) begin
      if (load_valid) m_mem[load_addr] = load_data;
      if (start && !stop) begin n_run = 1; n_pc = 0; end
    end else if (stop) begin
      n_run = 0;
    end else begin
      w = m_mem[m_pc];
      n_pc = (m_pc + 1) % 16;
      case (w[19:16])
        4'hF: begin n_run = 0; n_done = 1; n_pc = m_pc; end
        4'h1: n_pc = w[3:0];
        4'h6: if (z_flag)  n_pc = w[3:0];
        4'h7: if (!z_flag) n_pc = w[3:0];
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_run = n_run; m_pc = n_pc; m_done = n_done;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic load(input logic [3:0] a, input logic [19:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input int budget);
    int k = 0;
    while (m_run && k < budget) begin step(); k++; end
    chk("run_budget", {31'h0, m_run}, 32'h0);
    step();
  endtask

  logic [3:0] ops [7];
  int pcs[$];

  initial begin
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hF};
    reset = 1'b1; load_valid = 0; load_addr = 0; load_data = 0;
    start = 0; stop = 0; z_flag = 0;
    model_reset();
    #1;
    do_reset();

    // Straight-line program ending in HALT
    load(0, 20'h30005); load(1, 20'h3010A); load(2, 20'h20001); load(3, 20'hF0000);
    pulse_start();
    pcs = {};
    while (busy && pcs.size() < 20) begin pcs.push_back(pc); step(); end
    chk("seq_len", pcs.size(), 4);
    chk("seq_pc3", pcs.size() > 3 ? pcs[3] : -1, 3);
    chk("halt_done", {31'h0, done}, 1);
    step();
    chk("done_1cyc", {31'h0, done}, 0);

    // JMP
    do_reset();
    load(0, 20'h10005); load(5, 20'hF0000);
    pulse_start();
    step();
    chk("jmp_pc", {28'h0, pc}, 5);
    run_to_idle(4);

    // BZ / BNZ under both flag values
    for (int v = 0; v < 4; v++) begin
      do_reset();
      load(0, (v < 2) ? 20'h60003 : 20'h70003); load(1, 20'hF0000); load(3, 20'hF0000);
      z_flag = v[0];
      pulse_start();
      step();
      chk("branch_pc", {28'h0, pc}, ((v < 2) == (v[0] == 1)) ? 3 : 1);
      z_flag = 0;
      run_to_idle(4);
    end

    // All-NOP wrap, then stop at pc=2
    do_reset();
    pulse_start();
    for (int i = 0; i < 18; i++) step();
    chk("wrap_pc", {28'h0, pc}, 2);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_pc", {28'h0, pc}, 2);
    chk("stop_instr", {12'h0, instruction}, 0);
    chk("stop_nodone", {31'h0, done}, 0);
    step();

    // Load and start ignored during RUN; reset mid-RUN
    load(1, 20'h20002);
    pulse_start();
    load(1, 20'hABCDE);
    start = 1; step(); step(); start = 0;
    stop = 1; step(); stop = 0;
    chk("mem1_kept", {12'h0, m_mem[1]}, 32'h20002);
    pulse_start();
    step();
    chk("mem1_fetch", {12'h0, instruction}, 32'h20002);
    step();
    do_reset();
    step();

    // Start and load in the same idle cycle; start+stop in idle stays idle
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("startstop_idle", {31'h0, busy}, 0);
    start = 1; load(0, 20'hF0000); start = 0;
    chk("same_cyc_instr", {12'h0, instruction}, 32'hF0000);
    step();
    chk("same_cyc_done", {31'h0, done}, 1);
    step();

    // Random programs and control
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int i = 0; i < 6; i++)
        load(4'($urandom_range(0, 15)),
             {ops[$urandom_range(0, 6)], 8'($urandom), 8'($urandom)});
      pulse_start();
      for (int c = 0; c < 40 && m_run; c++) begin
        z_flag     = 1'($urandom);
        stop       = ($urandom_range(0, 24) == 0);
        start      = 1'($urandom);
        load_valid = 1'($urandom);
        load_addr  = 4'($urandom);
        load_data  = 20'($urandom);
        step();
      end
      z_flag = 0; start = 0; load_valid = 0;
      stop = 1; step(); stop = 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-002 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately, independent of clk.
REQ-003 load_valid  input  1  program-word write request.
REQ-004 load_ready  output  1  high when a program write can be accepted.
REQ-005 load_addr  input  4  program memory word address, 0-15.
REQ-006 load_data  input  20  program word: [19:16] opcode, [15:8] p1, [7:0] p2.
REQ-007 start  input  1  begin execution at address 0.
REQ-008 stop  input  1  abort execution.
REQ-009 z_flag  input  1  zero flag from the downstream executor for the p1 of the instruction currently presented.
REQ-010 instruction  output  20  instruction word presented to the downstream executor.
REQ-011 pc  output  4  address of the instruction currently presented.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse when execution ends by HALT.

Function
REQ-014 Storage SHALL be a 16 x 20-bit program memory, written only on a rising clk edge with load_valid=1 and load_ready=1.
REQ-015 The FSM SHALL have two states: IDLE and RUN; load_ready=1 exactly in IDLE.
REQ-016 IDLE -> RUN SHALL occur on a clk edge with start=1; pc is loaded with 0 on that edge.
REQ-017 A load and a start in the same IDLE cycle SHALL both take effect; the written word is visible to the first RUN fetch.
REQ-018 In RUN, instruction SHALL equal mem[pc] combinationally; in IDLE, instruction SHALL be 20'h00000 (opcode 0000, NOP).
REQ-019 In RUN, one instruction SHALL issue per cycle; the default next pc is pc+1, wrapping 15 -> 0.
REQ-020 Sequencer-local opcodes SHALL be: 1111 HALT; 0001 JMP to p2[3:0]; 0110 BZ (jump to p2[3:0] if z_flag=1); 0111 BNZ (jump to p2[3:0] if z_flag=0).
REQ-021 Local opcodes SHALL still be driven on instruction, which the executor treats as no-ops, so that z_flag reflects register[p1] for BZ/BNZ.
REQ-022 z_flag SHALL be sampled at the clk edge ending the BZ/BNZ cycle; a not-taken branch goes to pc+1.
REQ-023 All other opcodes SHALL pass through with next pc = pc+1.
REQ-024 HALT SHALL be presented for one cycle; at the following edge the FSM goes to IDLE, pc is held, and done pulses high for exactly the next cycle.
REQ-025 stop=1 in RUN SHALL force IDLE at the next edge, with no done pulse and pc held; stop has priority over HALT and branch decisions in the same cycle.
REQ-026 start=1 while in RUN SHALL be ignored; stop=1 in IDLE SHALL be ignored; start and stop both high in IDLE SHALL leave the FSM in IDLE.
REQ-027 load_valid=1 while in RUN SHALL not write memory (load_ready=0).
REQ-028 busy SHALL be high exactly when the state is RUN.

Reset
REQ-029 reset=0 SHALL immediately produce: state IDLE, pc=0, done=0, busy=0, load_ready=1, instruction=20'h00000, and all 16 memory words cleared to 20'h00000.
REQ-030 Reset asserted mid-RUN SHALL abort execution with no done pulse; after release, the block waits in IDLE for start.

Verification
REQ-031 Load 0:20'h30005, 1:20'h3010A, 2:20'h20001, 3:20'hF0000; pulse start -> instruction shows 30005, 3010A, 20001, F0000 on consecutive cycles with pc 0,1,2,3; done pulses one cycle after F0000; busy=0.
REQ-032 Load 0:20'h10005, 5:20'hF0000 -> pc sequence 0,5; done pulses; addresses 1-4 never presented.
REQ-033 Load 0:20'h60003, 1:20'hF0000, 3:20'hF0000: with z_flag=1 during the BZ cycle -> pc 0,3; with z_flag=0 -> pc 0,1; BNZ (20'h70003) gives the opposite result.
REQ-034 Memory of all NOPs, start -> pc runs 0..15, 0, 1,...; wrap confirmed; stop asserted at pc=2 -> IDLE next cycle, instruction=20'h00000, pc=2, no done.
REQ-035 Assert load_valid in RUN with load_addr=1 and load_data=20'hABCDE -> mem[1] unchanged; start during RUN ignored; reset=0 mid-RUN -> all outputs at reset values without a clk edge.
REQ-036 Assert start and load_valid (addr 0, data 20'hF0000) in the same IDLE cycle -> first presented instruction is F0000; done pulses two cycles after start.
